// File: rtl/cart_mbc1.sv
// MBC1 cartridge responder: bank registers, address translation and a req/ack
// backing-memory port with a one-deep queue for RAM writes that arrive while busy.
module cart_mbc1 #(
  parameter int ROM_ADDR_W  = 21,
  parameter int RAM_ADDR_W  = 15,
  parameter int RAM_PRESENT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  input  logic        wr,
  input  logic        rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        overrun
);

  localparam logic [20:0] ROM_MASK = 21'((64'd1 << ROM_ADDR_W) - 64'd1);
  localparam logic [14:0] RAM_MASK = 15'((64'd1 << RAM_ADDR_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, BUSY, QDRAIN} state_t;

  state_t      state;
  logic        wr_q;
  logic        ram_en;
  logic [4:0]  bank1;
  logic [1:0]  bank2;
  logic        mode;
  logic [15:0] tag;
  logic        tag_valid;
  logic [15:0] req_a;
  logic        stale;
  logic        q_valid;
  logic [14:0] q_addr;
  logic [7:0]  q_data;

  logic        is_rom, is_ram, ram_ok, mapped;
  logic        wr_edge, reg_wr, ram_wr, inval;
  logic [1:0]  hi2;
  logic [20:0] rom_addr;
  logic [14:0] ram_addr;
  logic        tag_hit, can_issue, do_q, do_wr, do_rd, issue;
  logic        q_push, q_drop, ack_ok, rd_done;

  assign is_rom   = ~a[15];
  assign is_ram   = (a[15:13] == 3'b101);
  assign ram_ok   = (RAM_PRESENT != 0) && ram_en && is_ram;
  assign mapped   = is_rom | ram_ok;
  assign wr_edge  = wr & ~wr_q;
  assign reg_wr   = wr_edge & is_rom;
  assign ram_wr   = wr_edge & ram_ok;
  assign inval    = reg_wr | ram_wr;
  assign hi2      = mode ? bank2 : 2'b00;
  assign rom_addr = (a[14] ? {bank2, bank1, a[13:0]} : {hi2, 5'd0, a[13:0]}) & ROM_MASK;
  assign ram_addr = {hi2, a[12:0]} & RAM_MASK;
  assign tag_hit  = tag_valid && (a == tag);

  // A pending queued write always goes first; a write strobe beats a read.
  assign can_issue = (state == IDLE) || (state == QDRAIN);
  assign do_q      = can_issue && q_valid;
  assign do_wr     = (state == IDLE) && !q_valid && ram_wr;
  assign do_rd     = (state == IDLE) && !q_valid && !wr_edge && rd && mapped && !tag_hit;
  assign issue     = do_q | do_wr | do_rd;
  assign q_push    = ram_wr && (((state == BUSY) && !q_valid) || do_q);
  assign q_drop    = ram_wr && (state == BUSY) && q_valid;
  assign ack_ok    = (state == BUSY) && mem_ack;
  assign rd_done   = ack_ok && !mem_we;

  // Control: bank registers, FSM, queue occupancy, read tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      ram_en    <= 1'b0;
      bank1     <= 5'd1;
      bank2     <= 2'd0;
      mode      <= 1'b0;
      rdata     <= 8'hFF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      overrun   <= 1'b0;
      tag_valid <= 1'b0;
      stale     <= 1'b0;
      q_valid   <= 1'b0;
    end else begin
      wr_q <= wr;
      if (reg_wr) begin
        case (a[14:13])
          2'd0: ram_en <= (wdata[3:0] == 4'hA);
          2'd1: bank1  <= (wdata[4:0] == 5'd0) ? 5'd1 : wdata[4:0];
          2'd2: bank2  <= wdata[1:0];
          2'd3: mode   <= wdata[0];
          default: ;
        endcase
      end
      if (q_push)     q_valid <= 1'b1;
      else if (do_q)  q_valid <= 1'b0;
      if (q_drop) overrun <= 1'b1;

      if (rd_done)            rdata <= mem_rdata;
      else if (rd && !mapped) rdata <= 8'hFF;

      // A read whose banks changed under it returns data but is not cached
      if (inval || (rd && !mapped)) tag_valid <= 1'b0;
      else if (rd_done && !stale)   tag_valid <= 1'b1;

      case (state)
        IDLE, QDRAIN: begin
          if (issue) begin
            mem_req <= 1'b1;
            mem_we  <= ~do_rd;
            stale   <= 1'b0;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (inval) stale <= 1'b1;
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= (q_valid || q_push) ? QDRAIN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data: request payload, queued write and tag carry no reset
  always_ff @(posedge clk) begin
    if (do_q) begin
      mem_sel   <= 1'b1;
      mem_addr  <= {6'd0, q_addr};
      mem_wdata <= q_data;
    end else if (do_wr) begin
      mem_sel   <= 1'b1;
      mem_addr  <= {6'd0, ram_addr};
      mem_wdata <= wdata;
    end else if (do_rd) begin
      mem_sel   <= ~is_rom;
      mem_addr  <= is_rom ? rom_addr : {6'd0, ram_addr};
      req_a     <= a;
    end
    if (q_push) begin
      q_addr <= ram_addr;
      q_data <= wdata;
    end
    if (rd_done) tag <= req_a;
  end

endmodule

// File: tb/tb_cart_mbc1.sv
// Scoreboard bench for cart_mbc1: directed bus traffic, a latency-programmable
// backing-memory model, and a monitor checking every issued memory request.
module tb_cart_mbc1;

  logic        clk, rst;
  logic [15:0] a;
  logic [7:0]  wdata, rdata;
  logic        wr, rd;
  logic        mem_req, mem_we, mem_sel;
  logic [20:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  cart_mbc1 dut (
    .clk(clk), .rst(rst), .a(a), .wdata(wdata), .rdata(rdata), .wr(wr), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic        sel;
    logic [20:0] addr;
    logic [7:0]  wdata;
  } req_t;

  req_t exp_q[$];

  // Backing memory model
  logic [7:0]  ram_m [0:32767];
  int          ack_dly = 2;
  int          cnt = 0;
  logic        busy_m = 1'b0;
  logic        sel_m = 1'b0;
  logic [20:0] addr_m = '0;

  function automatic logic [7:0] rom_byte(logic [20:0] x);
    return x[7:0] ^ x[15:8] ^ {3'b000, x[20:16]} ^ 8'h5A;
  endfunction

  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    for (int i = 0; i < 32768; i++) ram_m[i] = 8'h00;
  end

  always @(posedge clk) begin
    mem_ack <= 1'b0;
    if (busy_m) begin
      if (cnt <= 1) begin
        mem_ack   <= 1'b1;
        mem_rdata <= sel_m ? ram_m[addr_m[14:0]] : rom_byte(addr_m);
        busy_m    <= 1'b0;
      end else begin
        cnt <= cnt - 1;
      end
    end else if (mem_req && !mem_ack) begin
      busy_m <= 1'b1;
      cnt    <= ack_dly;
      sel_m  <= mem_sel;
      addr_m <= mem_addr;
      if (mem_we && mem_sel) ram_m[mem_addr[14:0]] <= mem_wdata;
    end
  end

  // Monitor: every new request is compared with the next expected one
  logic req_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_req && !req_prev) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req actual we=%0b sel=%0b addr=%06h required none",
                 mem_we, mem_sel, mem_addr);
      end else begin
        req_t e;
        e = exp_q.pop_front();
        if (mem_we !== e.we || mem_sel !== e.sel || mem_addr !== e.addr ||
            (e.we && mem_wdata !== e.wdata)) begin
          errors++;
          $display("FAIL req actual we=%0b sel=%0b addr=%06h wdata=%02h required we=%0b sel=%0b addr=%06h wdata=%02h",
                   mem_we, mem_sel, mem_addr, mem_wdata, e.we, e.sel, e.addr, e.wdata);
        end
      end
    end
    req_prev = mem_req;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bus_write(logic [15:0] ad, logic [7:0] d);
    a = ad; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic ram_write(logic [15:0] ad, logic [7:0] d, logic [20:0] ea);
    exp_q.push_back('{we: 1'b1, sel: 1'b1, addr: ea, wdata: d});
    bus_write(ad, d);
  endtask

  task automatic do_read(string name, logic [15:0] ad, logic [20:0] ea, logic es, logic [7:0] ed);
    bit got = 0;
    exp_q.push_back('{we: 1'b0, sel: es, addr: ea, wdata: 8'h00});
    a = ad; rd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (mem_ack) begin got = 1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ack required=ack", name);
    end else begin
      @(negedge clk);
      check(name, rdata, ed);
    end
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; a = 16'h0000; wdata = 8'h00; wr = 1'b0; rd = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    // T1: reset state and first ROM read in bank 1
    check("T1_rdata_reset", rdata, 8'hFF);
    check("T1_req_reset", mem_req, 1'b0);
    check("T1_overrun_reset", overrun, 1'b0);
    @(posedge clk); #1;
    do_read("T1_read_4123", 16'h4123, 21'h004123, 1'b0, rom_byte(21'h004123));

    // T2: bank 0 written to bank1 behaves as bank 1
    bus_write(16'h2000, 8'h00);
    do_read("T2_read_4000", 16'h4000, 21'h004000, 1'b0, rom_byte(21'h004000));

    // T3: maximal banks with mode 1
    bus_write(16'h2000, 8'h1F);
    bus_write(16'h4000, 8'h03);
    bus_write(16'h6000, 8'h01);
    do_read("T3_read_7FFF", 16'h7FFF, 21'h1FFFFF, 1'b0, rom_byte(21'h1FFFFF));
    do_read("T3_read_0000", 16'h0000, 21'h180000, 1'b0, rom_byte(21'h180000));

    // T4: RAM disabled reads FF, then enabled write and read-back
    bus_write(16'h6000, 8'h00);
    a = 16'hA000; rd = 1'b1;
    repeat (3) @(negedge clk);
    check("T4_ram_off_rdata", rdata, 8'hFF);
    @(posedge clk); #1;
    rd = 1'b0;
    bus_write(16'h0000, 8'h0A);
    ram_write(16'hA005, 8'h5A, 21'h000005);
    idle(8);
    do_read("T4_read_A005", 16'hA005, 21'h000005, 1'b1, 8'h5A);
    bus_write(16'h6000, 8'h01);
    do_read("T4_ram_bank3", 16'hA005, 21'h006005, 1'b1, 8'h00);
    bus_write(16'h6000, 8'h00);
    check("T4_overrun_clear", overrun, 1'b0);

    // T5: slow memory, three back-to-back RAM writes
    ack_dly = 6;
    ram_write(16'hA010, 8'h11, 21'h000010);
    ram_write(16'hA011, 8'h22, 21'h000011);
    bus_write(16'hA012, 8'h33);
    idle(30);
    check("T5_overrun", overrun, 1'b1);
    ack_dly = 2;
    do_read("T5_read_A010", 16'hA010, 21'h000010, 1'b1, 8'h11);
    do_read("T5_read_A011", 16'hA011, 21'h000011, 1'b1, 8'h22);
    do_read("T5_read_A012", 16'hA012, 21'h000012, 1'b1, 8'h00);

    // T6: reset during an outstanding request
    bus_write(16'h2000, 8'h07);
    bus_write(16'h4000, 8'h02);
    bus_write(16'h6000, 8'h01);
    ack_dly = 6;
    exp_q.push_back('{we: 1'b0, sel: 1'b0, addr: 21'h11C100, wdata: 8'h00});
    a = 16'h4100; rd = 1'b1;
    begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mem_req) begin seen = 1; break; end
      end
      if (!seen) begin
        checks++; errors++;
        $display("FAIL T6_req_timeout actual=no_req required=req");
      end
    end
    rst = 1'b1;
    #1;
    check("T6_req_drop", mem_req, 1'b0);
    rd = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(15);
    check("T6_req_idle", mem_req, 1'b0);
    check("T6_rdata_ff", rdata, 8'hFF);
    check("T6_overrun_rst", overrun, 1'b0);
    ack_dly = 2;
    do_read("T6_read_4123", 16'h4123, 21'h004123, 1'b0, rom_byte(21'h004123));
    do_read("T6_read_0000", 16'h0000, 21'h000000, 1'b0, rom_byte(21'h000000));
    a = 16'hA000; rd = 1'b1;
    repeat (3) @(negedge clk);
    check("T6_ram_off", rdata, 8'hFF);
    @(posedge clk); #1;
    rd = 1'b0;

    idle(5);
    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
